dispatch_stage: RTL and testbench
=================================

Name: dispatch_stage

Overview:
- In-order dispatch buffer between decode and execute.
- Queues decoded instructions and queries register_status for the head entry's rs1/rs2 readiness and data.
- Holds the head until both operands are valid, then issues it with captured operands over a valid/ready handshake.
- On issue, tells register_status to mark rd busy.

Parameters:
- DEPTH, 4, instruction queue entries; power of 2, minimum 2.
- CTRL_W, 16, opaque decoded-control bits passed through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all queued and in-flight entries.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  queue can accept.
- in_pc  in  32  instruction PC.
- in_ctrl  in  CTRL_W  decoded control.
- in_imm  in  32  immediate.
- in_rs1, in_rs2, in_rd  in  5 each  register indices.
- in_use_rs1, in_use_rs2, in_wr_rd  in  1 each  operand-use / write flags.
- rs1, rs2  out  5 each  index to register_status; head's sources, 0 when empty.
- rs1_valid, rs2_valid  in  1 each  register_status ready bits.
- rs1_data, rs2_data  in  32 each  register_status data.
- rd_alloc  out  1  one-cycle pulse: mark rd busy.
- rd_alloc_addr  out  5  rd being allocated.
- wb_valid  in  1  writeback broadcast valid.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback value.
- out_valid  out  1  issue valid.
- out_ready  in  1  execute accepts.
- out_pc  out  32  issued PC.
- out_ctrl  out  CTRL_W  issued control.
- out_imm  out  32  issued immediate.
- out_rd  out  5  issued destination.
- out_wr_rd  out  1  issued write flag.
- out_op1, out_op2  out  32 each  issued operands.

Behaviour:
- Reset (rst high at posedge):
  - count=0, pointers=0, state=IDLE.
  - in_ready=1; out_valid=0; rd_alloc=0; all out_* data=0; rs1=rs2=0; captured operand flags cleared.
- Queue:
  - Circular buffer with a count register. in_ready = (count != DEPTH), registered-count based.
  - A push while full is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Operand rules:
  - A source is satisfied when use=0, or index=0 (data forced 0), or its register_status valid bit is 1.
  - Each source captures data independently. Once captured, a source stays captured until issue.
- FSM:
  - IDLE: count==0. Go to LOOKUP when count becomes nonzero.
  - LOOKUP: sample both sources for the head.
    - Both satisfied -> ISSUE.
    - Otherwise -> WAIT.
  - WAIT: re-sample every cycle. Go to ISSUE when both sources are captured.
  - ISSUE:
    - out_valid=1 and out_* held stable until out_valid & out_ready.
    - On handshake: pop the head; rd_alloc=1 the next cycle with rd_alloc_addr=issued rd, only if wr_rd=1 and rd!=0.
    - Next state: LOOKUP if count after pop is nonzero, else IDLE.
- Latency: push at cycle N into an empty queue with ready operands -> out_valid at N+2.
- Issue rate: at most one issue every 2 cycles (LOOKUP between issues).
- flush:
  - Takes priority over push, pop and rd_alloc.
  - Next cycle: count=0, state=IDLE, out_valid=0, no rd_alloc for the flushed handshake.
- out_valid deasserts only after a handshake, flush or reset.

Optional Feature:
- Macro DISPATCH_WB_BYPASS_EN.
- Defined:
  - In LOOKUP and WAIT, an uncaptured source with index==wb_rd, wb_rd!=0 and wb_valid=1 captures wb_data that cycle.
  - If wb and register_status both qualify in the same cycle, wb_data wins.
- Undefined:
  - wb_* ports are present but ignored.
  - Sources are captured only from register_status.

Test Plan:
- Reset, then push one instruction: rs1=3, rs2=4, valids=1, data 0x11/0x22 -> out_valid at cycle +2, out_op1=0x11, out_op2=0x22.
- Head with rs1_valid=0 for 5 cycles then 1 (data 0xAB) -> state stays WAIT; issues the cycle after valid with out_op1=0xAB. rs2 captured earlier is retained.
- Sources rs1=0 and rs2=0 with use=1 -> issues with op1=op2=0 regardless of valid bits. rd=0 with wr_rd=1 -> no rd_alloc.
- Push 5 with out_ready=0 and DEPTH=4 -> in_ready=0 after 4 accepts. Then out_ready=1 -> entries issue in order; rd_alloc pulses carry each rd.
- flush while out_valid=1 and 3 entries queued -> next cycle out_valid=0, in_ready=1, no rd_alloc; a new push issues normally.
- With DISPATCH_WB_BYPASS_EN: head waits on rs2=7, wb_valid=1, wb_rd=7, wb_data=0x55 -> out_op2=0x55 issued next cycle.

Source files
------------

// File: rtl/dispatch_stage.sv
// dispatch_stage: in-order dispatch queue that gathers head operands from register_status and issues them.
// Optional macro DISPATCH_WB_BYPASS_EN lets a same-cycle writeback broadcast satisfy a waiting source.
module dispatch_stage #(
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [31:0]       in_imm,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic              in_wr_rd,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    input  logic              rs1_valid,
    input  logic              rs2_valid,
    input  logic [31:0]       rs1_data,
    input  logic [31:0]       rs2_data,
    output logic              rd_alloc,
    output logic [4:0]        rd_alloc_addr,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       out_imm,
    output logic [4:0]        out_rd,
    output logic              out_wr_rd,
    output logic [31:0]       out_op1,
    output logic [31:0]       out_op2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ISSUE  = 2'd3;

    logic [31:0]       q_pc   [DEPTH];
    logic [CTRL_W-1:0] q_ctrl [DEPTH];
    logic [31:0]       q_imm  [DEPTH];
    logic [4:0]        q_rs1  [DEPTH];
    logic [4:0]        q_rs2  [DEPTH];
    logic [4:0]        q_rd   [DEPTH];
    logic              q_use1 [DEPTH];
    logic              q_use2 [DEPTH];
    logic              q_wr   [DEPTH];

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [1:0]       state;

    logic        cap1, cap2;
    logic [31:0] op1_q, op2_q;
    logic        src1_sat, src2_sat;
    logic [31:0] src1_data, src2_data;
    logic        src1_ok, src2_ok;
    logic        push, pop;

    logic [4:0] head_rs1, head_rs2;
    logic       head_use1, head_use2;

    assign head_rs1  = q_rs1[head_ptr];
    assign head_rs2  = q_rs2[head_ptr];
    assign head_use1 = q_use1[head_ptr];
    assign head_use2 = q_use2[head_ptr];

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (state == S_ISSUE);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign rs1       = (count != '0) ? head_rs1 : 5'd0;
    assign rs2       = (count != '0) ? head_rs2 : 5'd0;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // An unused or x0 source is trivially satisfied with zero data.
    always_comb begin
        src1_sat  = 1'b0;
        src1_data = 32'd0;
        if (!head_use1 || head_rs1 == 5'd0) begin
            src1_sat = 1'b1;
`ifdef DISPATCH_WB_BYPASS_EN
        end else if (wb_valid && wb_rd != 5'd0 && wb_rd == head_rs1) begin
            src1_sat  = 1'b1;
            src1_data = wb_data;
`endif
        end else if (rs1_valid) begin
            src1_sat  = 1'b1;
            src1_data = rs1_data;
        end
    end

    always_comb begin
        src2_sat  = 1'b0;
        src2_data = 32'd0;
        if (!head_use2 || head_rs2 == 5'd0) begin
            src2_sat = 1'b1;
`ifdef DISPATCH_WB_BYPASS_EN
        end else if (wb_valid && wb_rd != 5'd0 && wb_rd == head_rs2) begin
            src2_sat  = 1'b1;
            src2_data = wb_data;
`endif
        end else if (rs2_valid) begin
            src2_sat  = 1'b1;
            src2_data = rs2_data;
        end
    end

`ifndef DISPATCH_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data};
`endif

    assign src1_ok = cap1 || src1_sat;
    assign src2_ok = cap2 || src2_sat;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc[tail_ptr]   <= in_pc;
            q_ctrl[tail_ptr] <= in_ctrl;
            q_imm[tail_ptr]  <= in_imm;
            q_rs1[tail_ptr]  <= in_rs1;
            q_rs2[tail_ptr]  <= in_rs2;
            q_rd[tail_ptr]   <= in_rd;
            q_use1[tail_ptr] <= in_use_rs1;
            q_use2[tail_ptr] <= in_use_rs2;
            q_wr[tail_ptr]   <= in_wr_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            head_ptr      <= '0;
            tail_ptr      <= '0;
            state         <= S_IDLE;
            cap1          <= 1'b0;
            cap2          <= 1'b0;
            op1_q         <= 32'd0;
            op2_q         <= 32'd0;
            rd_alloc      <= 1'b0;
            rd_alloc_addr <= 5'd0;
            out_pc        <= 32'd0;
            out_ctrl      <= '0;
            out_imm       <= 32'd0;
            out_rd        <= 5'd0;
            out_wr_rd     <= 1'b0;
            out_op1       <= 32'd0;
            out_op2       <= 32'd0;
        end else if (flush) begin
            count    <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            state    <= S_IDLE;
            cap1     <= 1'b0;
            cap2     <= 1'b0;
            rd_alloc <= 1'b0;
        end else begin
            rd_alloc <= 1'b0;
            count    <= count_next;
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            case (state)
                S_IDLE: begin
                    if (count_next != '0) state <= S_LOOKUP;
                end
                S_LOOKUP, S_WAIT: begin
                    if (!cap1 && src1_sat) begin
                        cap1  <= 1'b1;
                        op1_q <= src1_data;
                    end
                    if (!cap2 && src2_sat) begin
                        cap2  <= 1'b1;
                        op2_q <= src2_data;
                    end
                    // Issue payload is frozen here so it stays stable while execute stalls.
                    if (src1_ok && src2_ok) begin
                        state     <= S_ISSUE;
                        out_pc    <= q_pc[head_ptr];
                        out_ctrl  <= q_ctrl[head_ptr];
                        out_imm   <= q_imm[head_ptr];
                        out_rd    <= q_rd[head_ptr];
                        out_wr_rd <= q_wr[head_ptr];
                        out_op1   <= cap1 ? op1_q : src1_data;
                        out_op2   <= cap2 ? op2_q : src2_data;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_ISSUE: begin
                    if (pop) begin
                        cap1          <= 1'b0;
                        cap2          <= 1'b0;
                        rd_alloc      <= out_wr_rd && (out_rd != 5'd0);
                        rd_alloc_addr <= out_rd;
                        state         <= (count_next != '0) ? S_LOOKUP : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: scoreboard bench for dispatch_stage with a simple register_status model.
// Directed scenarios followed by a randomized phase; a negedge monitor checks every issue and rd_alloc.
module tb_dispatch_stage;
    localparam int DEPTH  = 4;
    localparam int CTRL_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, in_valid, in_ready;
    logic [31:0]       in_pc, in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_use_rs1, in_use_rs2, in_wr_rd;
    logic [4:0]        rs1, rs2;
    logic              rs1_valid, rs2_valid;
    logic [31:0]       rs1_data, rs2_data;
    logic              rd_alloc;
    logic [4:0]        rd_alloc_addr;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              out_valid, out_ready;
    logic [31:0]       out_pc, out_imm, out_op1, out_op2;
    logic [CTRL_W-1:0] out_ctrl;
    logic [4:0]        out_rd;
    logic              out_wr_rd;

    dispatch_stage #(.DEPTH(DEPTH), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ctrl(in_ctrl), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_rd(in_wr_rd),
        .rs1(rs1), .rs2(rs2), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_alloc(rd_alloc), .rd_alloc_addr(rd_alloc_addr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctrl(out_ctrl),
        .out_imm(out_imm), .out_rd(out_rd), .out_wr_rd(out_wr_rd),
        .out_op1(out_op1), .out_op2(out_op2)
    );

    typedef struct {
        logic [31:0]       pc;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       imm;
        logic [4:0]        rs1, rs2, rd;
        logic              use1, use2, wr_rd;
        logic [31:0]       op1, op2;
    } instr_t;

    instr_t      sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] reg_val [32];
    logic        reg_rdy [32];
    logic        alloc_exp = 1'b0;
    logic [4:0]  alloc_addr_exp = 5'd0;

    // Register-status model: ready bits and values live in plain arrays.
    assign rs1_valid = reg_rdy[rs1];
    assign rs2_valid = reg_rdy[rs2];
    assign rs1_data  = reg_val[rs1];
    assign rs2_data  = reg_val[rs2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mkInstr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                       input logic u1, input logic u2, input logic wr);
        instr_t t;
        t.pc    = 32'($urandom) & 32'hFFFF_FFFC;
        t.ctrl  = CTRL_W'($urandom);
        t.imm   = 32'($urandom);
        t.rs1   = r1;
        t.rs2   = r2;
        t.rd    = rd;
        t.use1  = u1;
        t.use2  = u2;
        t.wr_rd = wr;
        t.op1   = (r1 == 5'd0) ? 32'd0 : reg_val[r1];
        t.op2   = (r2 == 5'd0) ? 32'd0 : reg_val[r2];
        return t;
    endfunction

    task automatic driveFields(input instr_t t);
        in_pc      = t.pc;
        in_ctrl    = t.ctrl;
        in_imm     = t.imm;
        in_rs1     = t.rs1;
        in_rs2     = t.rs2;
        in_rd      = t.rd;
        in_use_rs1 = t.use1;
        in_use_rs2 = t.use2;
        in_wr_rd   = t.wr_rd;
    endtask

    task automatic applyStimulus(input instr_t t);
        int n = 0;
        bit done = 0;
        driveFields(t);
        in_valid = 1'b1;
        while (!done && n < 200) begin
            if (in_ready) begin
                sb.push_back(t);
                done = 1;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL push_timeout: got in_ready=0 for 200 cycles expected acceptance");
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        checkOutput("drain_empty", 32'(sb.size() == 0 && !out_valid), 32'd1);
        tick();
        tick();
    endtask

    // Monitor: pops the scoreboard on each handshake and checks the rd_alloc pulse that follows.
    initial begin
        instr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                alloc_exp = 1'b0;
            end else begin
                if (alloc_exp || rd_alloc) begin
                    checkOutput("rd_alloc", 32'(rd_alloc), 32'(alloc_exp));
                    if (alloc_exp) checkOutput("rd_alloc_addr", 32'(rd_alloc_addr), 32'(alloc_addr_exp));
                end
                alloc_exp = 1'b0;
                if (flush) begin
                    sb.delete();
                end else if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_issue: got pc %h expected no issue", out_pc);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("out_pc", out_pc, e.pc);
                        checkOutput("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
                        checkOutput("out_imm", out_imm, e.imm);
                        checkOutput("out_rd", 32'(out_rd), 32'(e.rd));
                        checkOutput("out_wr_rd", 32'(out_wr_rd), 32'(e.wr_rd));
                        if (e.use1) checkOutput("out_op1", out_op1, e.op1);
                        if (e.use2) checkOutput("out_op2", out_op2, e.op2);
                        alloc_exp      = e.wr_rd && (e.rd != 5'd0);
                        alloc_addr_exp = e.rd;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish by time limit expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t t;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        driveFields(mkInstr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 32; i++) begin
            reg_val[i] = 32'h1000 + 32'(i);
            reg_rdy[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_rd_alloc", 32'(rd_alloc), 32'd0);
        checkOutput("rst_rs1", 32'(rs1), 32'd0);
        checkOutput("rst_rs2", 32'(rs2), 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'd0);
        checkOutput("rst_out_op1", out_op1, 32'd0);

        $display("[TB] latency: push into empty queue with ready operands");
        out_ready = 1'b1;
        reg_val[3] = 32'h11;
        reg_val[4] = 32'h22;
        applyStimulus(mkInstr(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1));
        checkOutput("lat_n1_out_valid", 32'(out_valid), 32'd0);
        checkOutput("lat_n1_rs1", 32'(rs1), 32'd3);
        checkOutput("lat_n1_rs2", 32'(rs2), 32'd4);
        tick();
        checkOutput("lat_n2_out_valid", 32'(out_valid), 32'd1);
        drain();

        $display("[TB] wait: rs1 not ready for 5 cycles, rs2 captured early");
        reg_val[5] = 32'd0;
        reg_rdy[5] = 1'b0;
        reg_val[6] = 32'h66;
        t = mkInstr(5'd5, 5'd6, 5'd9, 1'b1, 1'b1, 1'b1);
        t.op1 = 32'hAB;
        applyStimulus(t);
        tick();
        reg_val[6] = 32'hDEAD;
        reg_rdy[6] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("wait_hold_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        reg_val[5] = 32'hAB;
        reg_rdy[5] = 1'b1;
        tick();
        checkOutput("wait_release_out_valid", 32'(out_valid), 32'd1);
        reg_rdy[6] = 1'b1;
        drain();

        $display("[TB] x0 sources and rd=0");
        reg_rdy[0] = 1'b0;
        reg_val[0] = 32'hFFFF_FFFF;
        applyStimulus(mkInstr(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1));
        tick();
        checkOutput("zero_issue_out_valid", 32'(out_valid), 32'd1);
        drain();
        reg_rdy[0] = 1'b1;

        $display("[TB] full queue backpressure");
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(mkInstr(5'd1, 5'd2, 5'(10 + i), 1'b1, 1'b1, 1'b1));
        tick();
        tick();
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        applyStimulus(mkInstr(5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 1'b1));
        drain();

        $display("[TB] flush with entries queued");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(mkInstr(5'd1, 5'd2, 5'(17 + i), 1'b1, 1'b1, 1'b1));
        checkOutput("flush_pre_out_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(mkInstr(5'd3, 5'd4, 5'(20 + i), 1'b1, 1'b1, 1'b1));
        checkOutput("refill_in_ready", 32'(in_ready), 32'd0);
        drain();

`ifdef DISPATCH_WB_BYPASS_EN
        $display("[TB] writeback bypass");
        reg_rdy[7] = 1'b0;
        reg_val[7] = 32'h99;
        t = mkInstr(5'd0, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0);
        t.op2 = 32'h55;
        applyStimulus(t);
        tick();
        tick();
        checkOutput("byp_hold_out_valid", 32'(out_valid), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        tick();
        wb_valid = 1'b0;
        checkOutput("byp_issue_out_valid", 32'(out_valid), 32'd1);
        drain();
        reg_rdy[7] = 1'b1;

        reg_rdy[8] = 1'b0;
        t = mkInstr(5'd8, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
        t.op1 = 32'h77;
        applyStimulus(t);
        tick();
        reg_rdy[8] = 1'b1;
        reg_val[8] = 32'h66;
        wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h77;
        tick();
        wb_valid = 1'b0;
        checkOutput("byp_prio_out_valid", 32'(out_valid), 32'd1);
        drain();
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 32; i++) reg_val[i] = 32'($urandom);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 32; i++) reg_rdy[i] = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = 1'($urandom_range(0, 1));
            wb_rd     = 5'($urandom);
            wb_data   = reg_val[wb_rd];
            if ($urandom_range(0, 1) == 1) begin
                t = mkInstr(5'($urandom), 5'($urandom), 5'($urandom),
                            1'($urandom), 1'($urandom), 1'($urandom));
                driveFields(t);
                in_valid = 1'b1;
                if (in_ready) sb.push_back(t);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        wb_valid = 1'b0;
        for (int i = 0; i < 32; i++) reg_rdy[i] = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
